// File: rtl/tlp_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tlp_tx_scheduler                                           |
// | Description : Pops a TLP header, then its payload beats, and emits them   |
// |               as one contiguous SOP/EOP-framed beat stream, gated by      |
// |               link header/data flow-control credits.                      |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tlp_tx_scheduler #(
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128,
    parameter int PH_W       = 8,
    parameter int PD_W       = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hdr_fifo_empty,
    input  logic [HDR_WIDTH-1:0]  hdr_fifo_rdata,
    output logic                  hdr_fifo_rden,
    input  logic                  pld_fifo_empty,
    input  logic [DATA_WIDTH:0]   pld_fifo_rdata,
    output logic                  pld_fifo_rden,
    input  logic                  cred_load,
    input  logic [PH_W-1:0]       cred_init_ph,
    input  logic [PD_W-1:0]       cred_init_pd,
    input  logic [PH_W-1:0]       cred_ret_ph,
    input  logic [PD_W-1:0]       cred_ret_pd,
    output logic                  tlp_valid,
    input  logic                  tlp_ready,
    output logic [DATA_WIDTH-1:0] tlp_data,
    output logic                  tlp_sop,
    output logic                  tlp_eop,
    output logic                  len_err,
    output logic                  busy
);

    // Beat counter holds up to 256 beats (1024 DW at the narrowest 128-bit width).
    localparam int BEAT_W = 9;
    localparam int CW     = 16;
    localparam int K      = DATA_WIDTH / 128;
    localparam int PDX    = PD_W + 1;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [BEAT_W-1:0]     w_beat_cnt_nxt;
    logic [PH_W-1:0]       r_ph_cnt;
    logic [PD_W-1:0]       r_pd_cnt;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_len_err;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_slot_free;
    logic                  w_has_data;
    logic [10:0]           w_len_dw;
    logic [CW-1:0]         w_dcred;
    logic [BEAT_W-1:0]     w_beats;
    logic                  w_pd_ok;
    logic                  w_launch;
    logic                  w_pop;
    logic                  w_last_beat;
    logic [PH_W-1:0]       w_ph_cons;
    logic [PD_W-1:0]       w_pd_cons;
    logic [PH_W:0]         w_ph_sum;
    logic [PD_W:0]         w_pd_sum;
    logic [DATA_WIDTH-1:0] w_hdr_ext;

    assign w_slot_free = !r_valid || tlp_ready;
    assign w_has_data  = hdr_fifo_rdata[30];
    // Length 0 encodes the maximum 1024 DW.
    assign w_len_dw    = (hdr_fifo_rdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr_fifo_rdata[9:0]};
    // Data credits are 16-byte (4 DW) units; beats are K such units wide.
    assign w_dcred     = CW'((w_len_dw + 11'd3) >> 2);
    assign w_beats     = BEAT_W'((w_dcred + CW'(K - 1)) / CW'(K));
    assign w_pd_ok     = !w_has_data || ({1'b0, r_pd_cnt} >= PDX'(w_dcred));
    assign w_last_beat = (r_beat_cnt == BEAT_W'(1));
    assign w_hdr_ext   = DATA_WIDTH'(hdr_fifo_rdata);

    // Next-state logic: header launch in IDLE, one payload pop per free slot in PAYLOAD.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_launch       = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!hdr_fifo_empty && w_slot_free && (r_ph_cnt != '0) && w_pd_ok) begin
                    w_launch = 1'b1;
                    if (w_has_data) begin
                        w_state_nxt    = S_PAYLOAD;
                        w_beat_cnt_nxt = w_beats;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!pld_fifo_empty && w_slot_free) begin
                    w_pop          = 1'b1;
                    w_beat_cnt_nxt = r_beat_cnt - BEAT_W'(1);
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Credit arithmetic: consumption never exceeds the count because launch checks it first.
    assign w_ph_cons = w_launch ? PH_W'(1) : '0;
    assign w_pd_cons = (w_launch && w_has_data) ? PD_W'(w_dcred) : '0;
    assign w_ph_sum  = {1'b0, r_ph_cnt} - {1'b0, w_ph_cons} + {1'b0, cred_ret_ph};
    assign w_pd_sum  = {1'b0, r_pd_cnt} - {1'b0, w_pd_cons} + {1'b0, cred_ret_pd};

    // Flow-control credit counters; load wins, otherwise saturating consume/return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph_cnt <= '0;
            r_pd_cnt <= '0;
        end else if (cred_load) begin
            r_ph_cnt <= cred_init_ph;
            r_pd_cnt <= cred_init_pd;
        end else begin
            r_ph_cnt <= w_ph_sum[PH_W] ? '1 : w_ph_sum[PH_W-1:0];
            r_pd_cnt <= w_pd_sum[PD_W] ? '1 : w_pd_sum[PD_W-1:0];
        end
    end

    // Output beat register: loads header or payload when the slot frees, else drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else if (w_launch) begin
            r_valid <= 1'b1;
            r_data  <= w_hdr_ext;
            r_sop   <= 1'b1;
            r_eop   <= !w_has_data;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_data  <= pld_fifo_rdata[DATA_WIDTH-1:0];
            r_sop   <= 1'b0;
            r_eop   <= w_last_beat;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
        end
    end

    // Framing check: stored last flag must agree with the header-derived beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_pop && (pld_fifo_rdata[DATA_WIDTH] != w_last_beat);
        end
    end

    assign hdr_fifo_rden = w_launch;
    assign pld_fifo_rden = w_pop;
    assign tlp_valid     = r_valid;
    assign tlp_data      = r_data;
    assign tlp_sop       = r_sop;
    assign tlp_eop       = r_eop;
    assign len_err       = r_len_err;
    assign busy          = (r_state != S_IDLE) || r_valid;

endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tlp_tx_scheduler                                        |
// | Description : Scoreboard bench for tlp_tx_scheduler with FWFT FIFO models |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_tlp_tx_scheduler;

    localparam int DW   = 256;
    localparam int HW   = 128;
    localparam int PH_W = 8;
    localparam int PD_W = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            hdr_fifo_empty = 1'b1;
    logic [HW-1:0]   hdr_fifo_rdata = '0;
    logic            hdr_fifo_rden;
    logic            pld_fifo_empty = 1'b1;
    logic [DW:0]     pld_fifo_rdata = '0;
    logic            pld_fifo_rden;
    logic            cred_load = 1'b0;
    logic [PH_W-1:0] cred_init_ph = '0;
    logic [PD_W-1:0] cred_init_pd = '0;
    logic [PH_W-1:0] cred_ret_ph = '0;
    logic [PD_W-1:0] cred_ret_pd = '0;
    logic            tlp_valid;
    logic            tlp_ready = 1'b1;
    logic [DW-1:0]   tlp_data;
    logic            tlp_sop;
    logic            tlp_eop;
    logic            len_err;
    logic            busy;

    tlp_tx_scheduler #(
        .DATA_WIDTH(DW), .HDR_WIDTH(HW), .PH_W(PH_W), .PD_W(PD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .hdr_fifo_empty(hdr_fifo_empty), .hdr_fifo_rdata(hdr_fifo_rdata), .hdr_fifo_rden(hdr_fifo_rden),
        .pld_fifo_empty(pld_fifo_empty), .pld_fifo_rdata(pld_fifo_rdata), .pld_fifo_rden(pld_fifo_rden),
        .cred_load(cred_load), .cred_init_ph(cred_init_ph), .cred_init_pd(cred_init_pd),
        .cred_ret_ph(cred_ret_ph), .cred_ret_pd(cred_ret_pd),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
        .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t         exp_q[$];
    logic [HW-1:0] hq[$];
    logic [DW:0]   pq[$];
    int            acc_cyc[$];
    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int n_hpop   = 0;
    int n_ppop   = 0;
    int n_acc    = 0;
    int n_lerr   = 0;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // FWFT FIFO models: pop on the edge that sees rden, present the new head shortly after.
    always @(posedge clk) begin
        if (hdr_fifo_rden) begin
            n_hpop = n_hpop + 1;
            if (hq.size() > 0) hq.delete(0);
        end
        if (pld_fifo_rden) begin
            n_ppop = n_ppop + 1;
            if (pq.size() > 0) pq.delete(0);
        end
        #2;
        hdr_fifo_empty = (hq.size() == 0);
        hdr_fifo_rdata = (hq.size() == 0) ? '0 : hq[0];
        pld_fifo_empty = (pq.size() == 0);
        pld_fifo_rdata = (pq.size() == 0) ? '0 : pq[0];
    end

    // Monitor: compares accepted beats against the scoreboard and checks stall stability.
    logic          p_stall = 1'b0;
    logic [DW-1:0] p_data  = '0;
    logic          p_sop   = 1'b0;
    logic          p_eop   = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                n_checks = n_checks + 1;
                if (!tlp_valid || tlp_data !== p_data || tlp_sop !== p_sop || tlp_eop !== p_eop) begin
                    n_errs = n_errs + 1;
                    $display("FAIL hold: valid=%0b sop=%0b eop=%0b data=%h, required held sop=%0b eop=%0b data=%h",
                             tlp_valid, tlp_sop, tlp_eop, tlp_data, p_sop, p_eop, p_data);
                end
            end
            if (tlp_valid && tlp_ready) begin
                n_checks = n_checks + 1;
                n_acc    = n_acc + 1;
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_errs = n_errs + 1;
                    $display("FAIL beat: unexpected beat sop=%0b eop=%0b data=%h, required none",
                             tlp_sop, tlp_eop, tlp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tlp_data !== e.d || tlp_sop !== e.sop || tlp_eop !== e.eop) begin
                        n_errs = n_errs + 1;
                        $display("FAIL beat: got sop=%0b eop=%0b data=%h, required sop=%0b eop=%0b data=%h",
                                 tlp_sop, tlp_eop, tlp_data, e.sop, e.eop, e.d);
                    end
                end
            end
            if (len_err === 1'b1) n_lerr = n_lerr + 1;
            p_stall = tlp_valid && !tlp_ready;
            p_data  = tlp_data;
            p_sop   = tlp_sop;
            p_eop   = tlp_eop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        n_checks = n_checks + 1;
        if (got !== req) begin
            n_errs = n_errs + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic load_cred(input int ph, input int pd);
        cred_load    = 1'b1;
        cred_init_ph = PH_W'(ph);
        cred_init_pd = PD_W'(pd);
        tick();
        cred_load    = 1'b0;
    endtask

    // Queue a header (and payload) into the FIFO models and the expected stream.
    // flip_idx selects one payload beat whose stored last flag is inverted (-1: none).
    task automatic push_tlp(input logic [31:0] tag, input logic hd, input logic [9:0] len,
                            input int nbeats, input int flip_idx);
        logic [HW-1:0] h;
        logic [31:0]   w;
        logic [DW-1:0] d;
        logic          last;
        h       = {tag, 96'h0};
        h[30]   = hd;
        h[9:0]  = len;
        hq.push_back(h);
        exp_q.push_back('{d: {{(DW-HW){1'b0}}, h}, sop: 1'b1, eop: !hd});
        for (int i = 0; i < nbeats; i++) begin
            w    = tag + 32'(i);
            d    = {8{w}};
            last = (i == nbeats - 1) ^ (i == flip_idx);
            pq.push_back({last, d});
            exp_q.push_back('{d: d, sop: 1'b0, eop: (i == nbeats - 1)});
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, b_acc, b_hpop, b_ppop, b_lerr;

        // Reset state
        repeat (3) tick();
        check("rst_valid", int'(tlp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sop", int'(tlp_sop), 0);
        check("rst_len_err", int'(len_err), 0);
        check("rst_hdr_rden", int'(hdr_fifo_rden), 0);
        check("rst_ph", int'(dut.r_ph_cnt), 0);
        rst = 1'b0;
        tick();

        // T1: L=16 data TLP, header + 2 payload beats back to back
        load_cred(4, 64);
        tick();
        acc_cyc.delete();
        b_lerr = n_lerr;
        c = cyc;
        push_tlp(32'hA000_0010, 1'b1, 10'd16, 2, -1);
        drain("t1_drain", 20);
        check("t1_hdr_latency", acc_cyc[0], c + 1);
        check("t1_beat1_cycle", acc_cyc[1], c + 2);
        check("t1_beat2_cycle", acc_cyc[2], c + 3);
        check("t1_ph_cnt", int'(dut.r_ph_cnt), 3);
        check("t1_pd_cnt", int'(dut.r_pd_cnt), 60);
        check("t1_len_err", n_lerr - b_lerr, 0);

        // T2: two no-data headers, one header credit
        load_cred(1, 0);
        tick();
        acc_cyc.delete();
        b_acc  = n_acc;
        b_hpop = n_hpop;
        push_tlp(32'hB000_0001, 1'b0, 10'd1, 0, -1);
        push_tlp(32'hB000_0002, 1'b0, 10'd1, 0, -1);
        repeat (5) tick();
        check("t2_first_only", n_acc - b_acc, 1);
        check("t2_hdr_pops", n_hpop - b_hpop, 1);
        c = cyc;
        cred_ret_ph = PH_W'(1);
        tick();
        cred_ret_ph = '0;
        drain("t2_drain", 10);
        check("t2_second_cycle", acc_cyc[1], c + 2);

        // T3: L=0 (1024 DW) needs 256 data credits
        load_cred(4, 255);
        tick();
        b_acc  = n_acc;
        b_hpop = n_hpop;
        b_ppop = n_ppop;
        push_tlp(32'hC000_0000, 1'b1, 10'd0, 128, -1);
        repeat (5) tick();
        check("t3_blocked_beats", n_acc - b_acc, 0);
        check("t3_blocked_pops", n_hpop - b_hpop, 0);
        cred_ret_pd = PD_W'(1);
        tick();
        cred_ret_pd = '0;
        drain("t3_drain", 400);
        check("t3_payload_pops", n_ppop - b_ppop, 128);
        check("t3_pd_cnt", int'(dut.r_pd_cnt), 0);
        check("t3_ph_cnt", int'(dut.r_ph_cnt), 3);

        // T4: framing mismatches (L=8 missing last, L=16 early last)
        load_cred(4, 64);
        tick();
        b_lerr = n_lerr;
        b_ppop = n_ppop;
        push_tlp(32'hD000_0008, 1'b1, 10'd8, 1, 0);
        push_tlp(32'hD000_0010, 1'b1, 10'd16, 2, 0);
        drain("t4_drain", 20);
        check("t4_len_err_pulses", n_lerr - b_lerr, 2);
        check("t4_payload_pops", n_ppop - b_ppop, 3);
        check("t4_pd_cnt", int'(dut.r_pd_cnt), 58);

        // T5: ready toggling during a 4-beat TLP
        b_hpop = n_hpop;
        b_ppop = n_ppop;
        push_tlp(32'hE000_0018, 1'b1, 10'd24, 3, -1);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            tick();
            tlp_ready = !tlp_ready;
        end
        tlp_ready = 1'b1;
        drain("t5_drain", 10);
        check("t5_hdr_pops", n_hpop - b_hpop, 1);
        check("t5_payload_pops", n_ppop - b_ppop, 3);

        // T6: reset during the second payload beat, then relaunch after reload
        b_acc = n_acc;
        push_tlp(32'hF000_0018, 1'b1, 10'd24, 3, -1);
        for (int k = 0; k < 20 && n_acc < b_acc + 2; k++) tick();
        check("t6_pre_reset_beats", n_acc - b_acc, 2);
        rst = 1'b1;
        tick();
        check("t6_valid", int'(tlp_valid), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_ph_cnt", int'(dut.r_ph_cnt), 0);
        check("t6_pd_cnt", int'(dut.r_pd_cnt), 0);
        exp_q.delete();
        pq.delete();
        rst = 1'b0;
        tick();
        b_acc = n_acc;
        push_tlp(32'hF100_0001, 1'b0, 10'd1, 0, -1);
        repeat (4) tick();
        check("t6_no_credit_launch", n_acc - b_acc, 0);
        load_cred(2, 16);
        drain("t6_drain", 10);
        check("t6_relaunch_beats", n_acc - b_acc, 1);
        check("t6_ph_after", int'(dut.r_ph_cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlp_tx_scheduler.md
# tlp_tx_scheduler

Sequences outgoing TLPs from the transaction layer to the data link layer. Pops one header from the header FIFO, then the matching number of beats from the payload FIFO (the FIFO written by the AXI W-channel payload handler), and emits them as one contiguous beat stream with SOP/EOP marking. Launch is gated by link flow-control header/data credits, and the block checks payload framing (the stored wlast bit) against the header length field.

## Interface
- DATA_WIDTH, PCIE_PKG::PIPE_DATA_WIDTH (256): payload/output beat width in bits; must be a multiple of 128.
- HDR_WIDTH, 128: header width (4DW TLP header).
- PH_W, 8: header credit counter width.
- PD_W, 12: data credit counter width (16-byte units).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- hdr_fifo_empty  in  1  header FIFO empty (first-word-fall-through).
- hdr_fifo_rdata  in  HDR_WIDTH  header at FIFO head; [9:0] length in DW (0 = 1024), [30] has_data.
- hdr_fifo_rden  out  1  pop header (combinational).
- pld_fifo_empty  in  1  payload FIFO empty (FWFT).
- pld_fifo_rdata  in  DATA_WIDTH+1  payload beat; MSB = stored last flag.
- pld_fifo_rden  out  1  pop payload beat (combinational).
- cred_load  in  1  load counters with init values.
- cred_init_ph  in  PH_W  initial header credits.
- cred_init_pd  in  PD_W  initial data credits.
- cred_ret_ph  in  PH_W  header credits returned this cycle.
- cred_ret_pd  in  PD_W  data credits returned this cycle.
- tlp_valid  out  1  output beat valid.
- tlp_ready  in  1  downstream accepts the beat.
- tlp_data  out  DATA_WIDTH  output beat.
- tlp_sop  out  1  first beat of TLP.
- tlp_eop  out  1  last beat of TLP.
- len_err  out  1  one-cycle pulse on a framing mismatch.
- busy  out  1  state != IDLE or tlp_valid.

## Operation
- Beat count per TLP: B = ceil(L*32/DATA_WIDTH), where L = length (0 maps to 1024). With DATA_WIDTH=256, B = ceil(L/8).
- Data credits per TLP: D = ceil(L/4), so L=1024 gives D=256. Header credits: 1.
- Output register slot is free when !tlp_valid || tlp_ready.
- State machine:
  - **IDLE**
    - Launches when all of these hold: !hdr_fifo_empty, slot free, ph_cnt ≥ 1, and (has_data = 0 or pd_cnt ≥ D).
    - On launch: assert hdr_fifo_rden.
    - Load the output register with the header zero-extended to DATA_WIDTH, sop=1, eop=!has_data.
    - Consume credits.
    - If has_data: go to PAYLOAD with beat_cnt = B. Otherwise stay in IDLE.
  - **PAYLOAD**
    - When !pld_fifo_empty and the slot is free: assert pld_fifo_rden.
    - Load tlp_data = pld_fifo_rdata[DATA_WIDTH-1:0], sop=0, eop=(beat_cnt==1).
    - Decrement beat_cnt. Return to IDLE after the beat with beat_cnt==1.
- Framing check on each popped beat:
  - Stored last flag must equal (beat_cnt==1). Otherwise, pulse len_err the next cycle.
  - beat_cnt stays authoritative. A mismatch does not abort, stall, or resynchronize.
- Credit counters:
  - Update: next = cur − consumed + returned, saturating at all-ones.
  - The launch check uses the current (registered) count. A return in the same cycle does not enable launch until the next cycle.
  - cred_load has priority over consume and return in the same cycle.
  - Counters reset to 0, so nothing launches until cred_load.
- No new header is popped while in PAYLOAD. TLPs never interleave.

## Timing
- Reset (async, active-high): state=IDLE, beat_cnt=0, ph_cnt=0, pd_cnt=0, tlp_valid=0, tlp_data=0, tlp_sop=0, tlp_eop=0, len_err=0. busy=0, hdr_fifo_rden=0 and pld_fifo_rden=0 follow from state.
- Reset mid-TLP drops the partial TLP. FIFO contents are not touched.
- Latency: launch-condition cycle N gives the header beat on tlp_valid in cycle N+1.
- Sustained throughput is one beat per cycle with tlp_ready=1 and the FIFOs non-empty. No bubble between header and first payload beat, or between back-to-back TLPs.
- tlp_valid/data/sop/eop hold stable while tlp_valid && !tlp_ready.
- An empty payload FIFO in PAYLOAD inserts bubbles (tlp_valid=0 after the current beat is accepted). State is kept.
- hdr_fifo_rden and pld_fifo_rden are never asserted in the same cycle.

## Test plan
- Credits ph=4, pd=64. Header L=16, has_data, 2 payload beats (last on beat 2), tlp_ready=1 -> 3 consecutive beats (sop on header, eop on beat 2); ph_cnt=3, pd_cnt=60; len_err=0.
- Two no-data headers back-to-back, ph=1 -> first emitted; second held until cred_ret_ph=1, then emitted the cycle after the return is registered.
- L=0 (1024 DW) with pd_cnt=255 -> no launch. cred_ret_pd=1 -> launch; 128 payload beats; pd_cnt=0 after.
- L=8, with payload last flag also set on beat 1 of a 2-beat TLP (L=16) -> len_err pulses once; still 2 payload beats emitted, eop on beat 2.
- tlp_ready toggled 1/0 every cycle during a 4-beat TLP -> each beat held stable while stalled; no beat lost or duplicated; FIFO rden count = 1 header + 3 payload.
- Assert rst during the second payload beat -> next cycle tlp_valid=0, busy=0, counters 0; after cred_load, the next header in the FIFO is launched normally.
